arb8_pri_rr: RTL and testbench

- Sequential 8-requester arbiter that shares one resource port among eight clients.
- Uses the same conventions as the 8-3 priority encoder: active-low requests, active-low enable iEI, inverted 3-bit index output, active-high "any granted" flag.
- Sits between client request lines and the shared resource mux; oGntIdx drives the mux select directly.
- Supports fixed-priority and round-robin modes, a bounded hold time, and a one-cycle turnaround between grants.

---
 rtl/arb8_pri_rr.sv | 113 +++++++++++
 tb/tb_arb8_pri_rr.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arb8_pri_rr.sv
// Eight-client resource arbiter with active-low requests/enable and an inverted index output.
// Fixed-priority or round-robin selection, bounded hold time, one idle turnaround cycle between grants.
module arb8_pri_rr #(
    parameter int PRI_MODE = 0,
    parameter int MAX_HOLD = 16
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic [7:0] iReq,
    input  logic       iEI,
    output logic [7:0] oGnt,
    output logic [2:0] oGntIdx,
    output logic       oEO,
    output logic       oTimeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LAST    = 8'(MAX_HOLD - 1);
    localparam bit         HOLD_LIMITED = (MAX_HOLD != 0);

    state_t     state;
    logic [2:0] gntIdx;
    logic [2:0] rrPtr;
    logic [7:0] holdCnt;

    logic       winValid;
    logic [2:0] winIdx;
    logic [2:0] cand;
    logic       relHit;
    logic       timeHit;

    // Later loop iterations overwrite earlier ones, so the scan order sets the winner.
    always_comb begin
        winValid = 1'b0;
        winIdx   = 3'd0;
        cand     = 3'd0;
        if (PRI_MODE != 0) begin
            for (int n = 0; n < 8; n++) begin
                if (!iReq[n]) begin
                    winValid = 1'b1;
                    winIdx   = 3'(n);
                end
            end
        end else begin
            // Offset 8 wraps to rrPtr itself: the last grantee is considered last.
            for (int i = 8; i >= 1; i--) begin
                cand = rrPtr + 3'(i);
                if (!iReq[cand]) begin
                    winValid = 1'b1;
                    winIdx   = cand;
                end
            end
        end
    end

    assign relHit  = iReq[gntIdx];
    assign timeHit = HOLD_LIMITED && (holdCnt == HOLD_LAST);

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state    <= IDLE;
            gntIdx   <= 3'd0;
            rrPtr    <= 3'd7;
            holdCnt  <= 8'd0;
            oGnt     <= 8'hFF;
            oGntIdx  <= 3'b111;
            oEO      <= 1'b0;
            oTimeout <= 1'b0;
        end else begin
            oTimeout <= 1'b0;
            case (state)
                IDLE, GAP: begin
                    if (!iEI && winValid) begin
                        state   <= GRANT;
                        gntIdx  <= winIdx;
                        rrPtr   <= winIdx;
                        holdCnt <= 8'd0;
                        oGnt    <= ~(8'b1 << winIdx);
                        oGntIdx <= ~winIdx;
                        oEO     <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                GRANT: begin
                    if (relHit || iEI || timeHit) begin
                        // A release or disable at the same edge takes precedence over preemption.
                        state    <= GAP;
                        holdCnt  <= 8'd0;
                        oGnt     <= 8'hFF;
                        oGntIdx  <= 3'b111;
                        oEO      <= 1'b0;
                        oTimeout <= timeHit && !relHit && !iEI;
                    end else begin
                        holdCnt <= holdCnt + 8'd1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    oGnt    <= 8'hFF;
                    oGntIdx <= 3'b111;
                    oEO     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arb8_pri_rr.sv
// Bench for arb8_pri_rr: three instances (fixed/16, round-robin/16, round-robin/4) on shared inputs,
// checked against directed vector tables and a per-instance behavioural model every cycle.
module tb_arb8_pri_rr;

    logic       iClk;
    logic       iRst;
    logic [7:0] iReq;
    logic       iEI;

    logic [7:0] gntF, gntR, gntT;
    logic [2:0] idxF, idxR, idxT;
    logic       eoF, eoR, eoT;
    logic       toF, toR, toT;

    arb8_pri_rr #(.PRI_MODE(1), .MAX_HOLD(16)) dutFix (
        .iClk(iClk), .iRst(iRst), .iReq(iReq), .iEI(iEI),
        .oGnt(gntF), .oGntIdx(idxF), .oEO(eoF), .oTimeout(toF)
    );
    arb8_pri_rr #(.PRI_MODE(0), .MAX_HOLD(16)) dutRr (
        .iClk(iClk), .iRst(iRst), .iReq(iReq), .iEI(iEI),
        .oGnt(gntR), .oGntIdx(idxR), .oEO(eoR), .oTimeout(toR)
    );
    arb8_pri_rr #(.PRI_MODE(0), .MAX_HOLD(4)) dutTo (
        .iClk(iClk), .iRst(iRst), .iReq(iReq), .iEI(iEI),
        .oGnt(gntT), .oGntIdx(idxT), .oEO(eoT), .oTimeout(toT)
    );

    initial begin
        iClk = 1'b0;
        forever #5 iClk = ~iClk;
    end

    int checks = 0;
    int errors = 0;
    logic [12:0] exp_q[$];
    string names [3] = '{"fix", "rr", "to"};

    // Abstract model: who holds the grant (-1 = nobody), completed cycles, last winner.
    typedef struct {
        int cur;
        int held;
        int last;
        bit tout;
    } mdl_t;

    mdl_t mF, mR, mT;

    typedef struct {
        int         sel;
        bit         rstBefore;
        logic [7:0] req;
        logic       en;
        int         client;
        bit         tout;
    } vec_t;

    vec_t vecs[$];

    function automatic mdl_t mdlReset();
        mdl_t m;
        m.cur  = -1;
        m.held = 0;
        m.last = 7;
        m.tout = 1'b0;
        return m;
    endfunction

    function automatic int pick(logic [7:0] req, int last, int priMode);
        if (priMode != 0) begin
            for (int n = 7; n >= 0; n--)
                if (req[n] == 1'b0) return n;
        end else begin
            for (int k = 1; k <= 8; k++) begin
                int c;
                c = (last + k) % 8;
                if (req[c] == 1'b0) return c;
            end
        end
        return -1;
    endfunction

    function automatic mdl_t mdlStep(mdl_t m, logic [7:0] req, logic enN, int priMode, int maxHold);
        mdl_t n;
        bit rel, tUp;
        n = m;
        n.tout = 1'b0;
        if (m.cur >= 0) begin
            rel = req[m.cur];
            tUp = (maxHold != 0) && (m.held + 1 == maxHold);
            if (rel || enN || tUp) begin
                n.cur  = -1;
                n.held = 0;
                n.tout = tUp && !rel && !enN;
            end else begin
                n.held = m.held + 1;
            end
        end else if (!enN) begin
            n.cur = pick(req, m.last, priMode);
            if (n.cur >= 0) begin
                n.last = n.cur;
                n.held = 0;
            end
        end
        return n;
    endfunction

    // Expected output bundle {oGnt, oGntIdx, oEO, oTimeout} for a granted client (or -1).
    function automatic logic [12:0] mk(int c, bit t);
        logic [7:0] one;
        logic [2:0] ci;
        if (c < 0) return {8'hFF, 3'b111, 1'b0, t};
        ci  = 3'(c);
        one = 8'b1 << ci;
        return {~one, ~ci, 1'b1, 1'b0};
    endfunction

    function automatic logic [12:0] outOf(int sel);
        case (sel)
            0:       return {gntF, idxF, eoF, toF};
            1:       return {gntR, idxR, eoR, toR};
            default: return {gntT, idxT, eoT, toT};
        endcase
    endfunction

    task automatic checkVal(string name, logic [12:0] act, logic [12:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got gnt=%h idx=%b eo=%b to=%b, want gnt=%h idx=%b eo=%b to=%b",
                     name, act[12:5], act[4:2], act[1], act[0], exp[12:5], exp[4:2], exp[1], exp[0]);
        end
    endtask

    task automatic resetModels();
        mF = mdlReset();
        mR = mdlReset();
        mT = mdlReset();
    endtask

    task automatic checkModels();
        checkVal("model_fix", outOf(0), mk(mF.cur, mF.tout));
        checkVal("model_rr",  outOf(1), mk(mR.cur, mR.tout));
        checkVal("model_to",  outOf(2), mk(mT.cur, mT.tout));
    endtask

    // One clock: advance the models on the inputs held across the edge, then compare just after it.
    task automatic tick();
        @(posedge iClk);
        if (iRst) begin
            resetModels();
        end else begin
            mF = mdlStep(mF, iReq, iEI, 1, 16);
            mR = mdlStep(mR, iReq, iEI, 0, 16);
            mT = mdlStep(mT, iReq, iEI, 0, 4);
        end
        #1;
        checkModels();
    endtask

    task automatic doReset();
        iReq = 8'hFF;
        iEI  = 1'b0;
        iRst = 1'b1;
        #1;
        resetModels();
        tick();
        iRst = 1'b0;
    endtask

    // Reset asserted between edges must clear every output before the next edge.
    task automatic midReset();
        #4;
        iRst = 1'b1;
        #1;
        resetModels();
        for (int s = 0; s < 3; s++) checkVal({"async_rst_", names[s]}, outOf(s), mk(-1, 1'b0));
        tick();
        iRst = 1'b0;
    endtask

    task automatic addVec(int sel, bit rb, logic [7:0] req, logic en, int client, bit tout);
        vec_t v;
        v.sel       = sel;
        v.rstBefore = rb;
        v.req       = req;
        v.en        = en;
        v.client    = client;
        v.tout      = tout;
        vecs.push_back(v);
    endtask

    initial begin
        iRst = 1'b0;
        iReq = 8'hFF;
        iEI  = 1'b0;
        resetModels();

        // Fixed priority: clients 0,5,7 -> 7, release 7 -> gap -> 5, then 0, then enable gating.
        addVec(0, 1, 8'h5E, 0,  7, 0);
        addVec(0, 0, 8'h5E, 0,  7, 0);
        addVec(0, 0, 8'hDE, 0, -1, 0);
        addVec(0, 0, 8'hDE, 0,  5, 0);
        addVec(0, 0, 8'hDE, 0,  5, 0);
        addVec(0, 0, 8'hFE, 0, -1, 0);
        addVec(0, 0, 8'hFE, 0,  0, 0);
        addVec(0, 0, 8'hFF, 0, -1, 0);
        addVec(0, 0, 8'hFF, 0, -1, 0);
        addVec(0, 0, 8'h7F, 1, -1, 0);
        addVec(0, 0, 8'h7F, 0,  7, 0);
        // Enable drop while client 5 holds the grant.
        addVec(0, 1, 8'hDF, 0,  5, 0);
        addVec(0, 0, 8'hDF, 0,  5, 0);
        addVec(0, 0, 8'hDF, 1, -1, 0);
        addVec(0, 0, 8'hDF, 1, -1, 0);
        addVec(0, 0, 8'h00, 1, -1, 0);
        addVec(0, 0, 8'h00, 1, -1, 0);
        addVec(0, 0, 8'hDF, 0,  5, 0);
        // Round robin over clients 1,3,6, each releasing after two grant cycles.
        addVec(1, 1, 8'hB5, 0,  1, 0);
        addVec(1, 0, 8'hB5, 0,  1, 0);
        addVec(1, 0, 8'hB7, 0, -1, 0);
        addVec(1, 0, 8'hB5, 0,  3, 0);
        addVec(1, 0, 8'hB5, 0,  3, 0);
        addVec(1, 0, 8'hBD, 0, -1, 0);
        addVec(1, 0, 8'hB5, 0,  6, 0);
        addVec(1, 0, 8'hB5, 0,  6, 0);
        addVec(1, 0, 8'hF5, 0, -1, 0);
        addVec(1, 0, 8'hB5, 0,  1, 0);
        // Hold limit 4 with clients 2 and 4 pending, ending in a release on the limit edge.
        addVec(2, 1, 8'hEB, 0,  2, 0);
        addVec(2, 0, 8'hEB, 0,  2, 0);
        addVec(2, 0, 8'hEB, 0,  2, 0);
        addVec(2, 0, 8'hEB, 0,  2, 0);
        addVec(2, 0, 8'hEB, 0, -1, 1);
        addVec(2, 0, 8'hEB, 0,  4, 0);
        addVec(2, 0, 8'hEB, 0,  4, 0);
        addVec(2, 0, 8'hEB, 0,  4, 0);
        addVec(2, 0, 8'hEB, 0,  4, 0);
        addVec(2, 0, 8'hEB, 0, -1, 1);
        addVec(2, 0, 8'hEB, 0,  2, 0);
        addVec(2, 0, 8'hEB, 0,  2, 0);
        addVec(2, 0, 8'hEB, 0,  2, 0);
        addVec(2, 0, 8'hEB, 0,  2, 0);
        addVec(2, 0, 8'hEF, 0, -1, 0);
        addVec(2, 0, 8'hEB, 0,  4, 0);

        #1;
        // Reset then idle for ten cycles.
        doReset();
        for (int c = 0; c < 10; c++) begin
            tick();
            for (int s = 0; s < 3; s++) checkVal({"idle_", names[s]}, outOf(s), mk(-1, 1'b0));
        end

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rstBefore) doReset();
            iReq = vecs[i].req;
            iEI  = vecs[i].en;
            exp_q.push_back(mk(vecs[i].client, vecs[i].tout));
            tick();
            checkVal({"vec_", names[vecs[i].sel]}, outOf(vecs[i].sel), exp_q.pop_front());
        end

        // Async reset while client 3 is granted, then the first round-robin pick starts at 0.
        doReset();
        iReq = 8'hF7;
        tick();
        checkVal("pre_rst_grant3", outOf(1), mk(3, 1'b0));
        tick();
        midReset();
        iReq = 8'hDB;
        tick();
        checkVal("post_rst_rr", outOf(1), mk(2, 1'b0));
        checkVal("post_rst_fix", outOf(0), mk(5, 1'b0));

        // Random traffic against the models, with occasional asynchronous resets.
        iReq = 8'($urandom);
        for (int c = 0; c < 600; c++) begin
            int b;
            b = $urandom_range(0, 7);
            if ($urandom_range(0, 3) == 0) iReq[b] = ~iReq[b];
            iEI = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 149) == 0) midReset();
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
